// File: rtl/rf_seq_ctrl.sv
// rtl/rf_seq_ctrl.sv - register-file read/ALU/write sequencer; optional busy-cycle counter via RF_SEQ_CYCLE_CNT_EN
module rf_seq_ctrl #(
    parameter int AW  = 5,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [AW-1:0]  len,
    input  logic [AW-1:0]  base,
    input  logic [OPW-1:0] op,
    output logic [AW-1:0]  addr1,
    output logic [AW-1:0]  addr2,
    output logic [AW-1:0]  addr3,
    output logic           write_enable,
    output logic [OPW-1:0] alu_op,
    output logic           busy,
    output logic           done
`ifdef RF_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]    cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  rem_q, rem_d;
    logic [AW-1:0]  a1_q, a1_d;
    logic [AW-1:0]  a2_q, a2_d;
    logic [AW-1:0]  a3_q, a3_d;
    logic [OPW-1:0] op_q, op_d;
    logic           accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        op_d    = op_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len != '0) begin
                        state_d = S_ISSUE;
                        rem_d   = len;
                        op_d    = op;
                        a3_d    = base;
                        a2_d    = base - AW'(1);
                        a1_d    = base - AW'(2);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            // ISSUE and WAIT cover the registered ALU latency before the write.
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: begin
                rem_d = rem_q - AW'(1);
                if (rem_q > AW'(1)) begin
                    state_d = S_ISSUE;
                    a1_d    = a1_q + AW'(1);
                    a2_d    = a2_q + AW'(1);
                    a3_d    = a3_q + AW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign addr1        = a1_q;
    assign addr2        = a2_q;
    assign addr3        = a3_q;
    assign alu_op       = op_q;
    assign write_enable = (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);

`ifdef RF_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (busy && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: doc/rf_seq_ctrl.md
RF_SEQ_CTRL -- requirements
Module: rf_seq_ctrl

Interface
REQ-001 Parameter AW, default 5: register-file address width.
REQ-002 Parameter OPW, default 5: ALU opcode width.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 len  input  AW  number of results to produce; captured on accepted start.
REQ-007 base  input  AW  destination address of first result; captured on accepted start.
REQ-008 op  input  OPW  ALU opcode; captured on accepted start.
REQ-009 addr1  output  AW  register-file read port 1 address (older operand).
REQ-010 addr2  output  AW  register-file read port 2 address (newer operand).
REQ-011 addr3  output  AW  register-file write address.
REQ-012 write_enable  output  1  register-file write strobe.
REQ-013 alu_op  output  OPW  opcode driven to ALU, held for whole sequence.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at end of sequence.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-017 IDLE + start=1, len!=0 -> ISSUE; captures len, op; sets addr3=base, addr2=base-1, addr1=base-2 (mod 2^AW).
REQ-018 IDLE + start=1, len=0 -> DONE directly; no write issued.
REQ-019 ISSUE -> WAIT -> WRITE unconditionally, one cycle each, covering the 1-cycle registered ALU latency.
REQ-020 write_enable SHALL be 1 only in WRITE, exactly one cycle per result.
REQ-021 addr1/addr2/addr3 SHALL be stable from ISSUE through WRITE of each step.
REQ-022 WRITE with remaining count >1 -> ISSUE; all three addresses increment by 1 mod 2^AW; remaining count decrements.
REQ-023 WRITE with remaining count =1 -> DONE.
REQ-024 DONE -> IDLE after one cycle; done=1 only in DONE.
REQ-025 Each result SHALL take exactly 3 cycles; a len=N sequence SHALL span 3N+1 busy cycles (start accept edge to IDLE return).
REQ-026 start while busy SHALL be ignored; captured values unaffected.
REQ-027 Address wrap: 31+1 -> 0; base=0 gives addr1=30, addr2=31; base=1 gives addr1=31, addr2=0.
REQ-028 No address is gated; writes to address 0 are issued as for any other address.
REQ-029 IDLE outputs: write_enable=0, done=0; addresses and alu_op hold last values.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, addr1=addr2=addr3=0, alu_op=0, write_enable=0, busy=0, done=0, remaining count=0.
REQ-031 rst SHALL take priority over start and over any in-progress state; reset during WRITE SHALL drop write_enable the following cycle and abandon the sequence with no done pulse.

Configuration
REQ-032 Macro RF_SEQ_CYCLE_CNT_EN defined: add output cycle_cnt (16 bits) counting cycles with busy=1, cleared on reset and on accepted start, saturating at 0xFFFF, held in IDLE.
REQ-033 Macro undefined: cycle_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 rst, then start with base=2, len=3, op=1 -> writes at addr3=2,3,4 with (addr1,addr2)=(0,1),(1,2),(2,3); write_enable high on cycles 3,6,9 after accept; done on cycle 10.
REQ-035 start with len=0 -> done pulse next cycle, write_enable never asserted, busy high for 1 cycle.
REQ-036 start with base=31, len=3 -> addr3 sequence 31,0,1; first step addr1=29, addr2=30.
REQ-037 start pulse mid-sequence with base=10, len=5 -> ignored; original sequence completes unchanged.
REQ-038 rst asserted in WRITE of step 2 of len=4 -> IDLE next cycle, all outputs at reset values, no done pulse.
REQ-039 With RF_SEQ_CYCLE_CNT_EN, len=2 -> cycle_cnt=7 after return to IDLE; held until next accepted start.
